jam_param: RTL and testbench

Parametrised job-assignment solver, successor to the fixed 8×8 JAM engine in the assignment-optimisation datapath. It enumerates all N! worker→job permutations in lexicographic order and fetches each cost through the same combinational W/J→Cost lookup port. It reports the best total cost (minimum or maximum, selected per run), how many permutations achieve it, and the first permutation that achieves it. Runs are started by a one-cycle handshake instead of free-running out of reset.

---
 rtl/jam_pkg.sv | 23 ++
 rtl/jam_perm_next.sv | 65 ++++++
 rtl/jam_param.sv | 131 +++++++++++++
 tb/tb_jam_param.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/jam_pkg.sv
// Shared definitions for the parametrised job-assignment solver.
package jam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_STEP = 2'd2,
        ST_DONE = 2'd3
    } jam_state_e;

    localparam logic MODE_MIN = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    function automatic int jam_idx_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    // Wide enough that N full-scale costs never wrap.
    function automatic int jam_sum_w(input int n, input int cost_w);
        return cost_w + $clog2(n);
    endfunction

endpackage

// File: rtl/jam_perm_next.sv
// Combinational next-lexicographic-permutation step; last=1 when the input is descending.
module jam_perm_next
    import jam_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N*IDX_W-1:0] perm,
    output logic [N*IDX_W-1:0] perm_next,
    output logic               last
);

    logic [IDX_W-1:0] p [N];
    logic [IDX_W-1:0] t [N];
    logic [IDX_W-1:0] s [N];
    logic [IDX_W-1:0] pv;
    logic [IDX_W-1:0] jv;
    logic             found;
    int               piv;
    int               jx;

    always_comb begin
        found     = 1'b0;
        piv       = 0;
        jx        = 0;
        pv        = '0;
        jv        = '0;
        perm_next = '0;
        for (int k = 0; k < N; k++) begin
            p[k] = perm[k*IDX_W +: IDX_W];
        end
        for (int i = 0; i < N - 1; i++) begin
            if (p[i] < p[i+1]) begin
                found = 1'b1;
                piv   = i;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (i == piv) pv = p[i];
        end
        // The suffix is descending, so the rightmost larger element is the smallest larger one.
        for (int j = 0; j < N; j++) begin
            if (j > piv && p[j] > pv) begin
                jx = j;
                jv = p[j];
            end
        end
        for (int k = 0; k < N; k++) begin
            t[k] = (k == piv) ? jv : ((k == jx) ? pv : p[k]);
        end
        for (int k = 0; k < N; k++) begin
            s[k] = t[k];
            if (k > piv) begin
                for (int m = 0; m < N; m++) begin
                    if (m == N + piv - k) s[k] = t[m];
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            perm_next[k*IDX_W +: IDX_W] = s[k];
        end
        last = !found;
    end

endmodule

// File: rtl/jam_param.sv
// Exhaustive N x N job-assignment solver: walks all N! permutations and keeps the best total cost.
module jam_param
    import jam_pkg::*;
#(
    parameter int  N      = 8,
    parameter int  COST_W = 7,
    localparam int IDX_W  = jam_idx_w(N),
    localparam int SUM_W  = jam_sum_w(N, COST_W)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic                 mode,
    output logic [IDX_W-1:0]     W,
    output logic [IDX_W-1:0]     J,
    input  logic [COST_W-1:0]    Cost,
    output logic [SUM_W-1:0]     BestCost,
    output logic [15:0]          MatchCount,
    output logic [N*IDX_W-1:0]   BestPerm,
    output logic                 busy,
    output logic                 Valid
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_EVAL = ST_EVAL;
    localparam logic [1:0] S_STEP = ST_STEP;
    localparam logic [1:0] S_DONE = ST_DONE;

    function automatic logic [N*IDX_W-1:0] identity_perm();
        logic [N*IDX_W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            r[k*IDX_W +: IDX_W] = IDX_W'(k);
        end
        return r;
    endfunction

    localparam logic [N*IDX_W-1:0] IDENT  = identity_perm();
    localparam logic [IDX_W-1:0]   W_LAST = IDX_W'(N - 1);

    logic [1:0]         state;
    logic [N*IDX_W-1:0] perm;
    logic [N*IDX_W-1:0] perm_nxt;
    logic               perm_last;
    logic [SUM_W-1:0]   acc;
    logic [SUM_W-1:0]   best;
    logic [15:0]        count;
    logic [N*IDX_W-1:0] best_perm;
    logic [IDX_W-1:0]   w_cnt;
    logic [IDX_W-1:0]   j_sel;
    logic               mode_r;
    logic               first;
    logic               better;

    jam_perm_next #(.N(N), .IDX_W(IDX_W)) u_next (
        .perm      (perm),
        .perm_next (perm_nxt),
        .last      (perm_last)
    );

    always_comb begin
        j_sel = '0;
        for (int k = 0; k < N; k++) begin
            if (w_cnt == IDX_W'(k)) j_sel = perm[k*IDX_W +: IDX_W];
        end
    end

    assign better = (mode_r == MODE_MAX) ? (acc > best) : (acc < best);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            perm      <= IDENT;
            acc       <= '0;
            w_cnt     <= '0;
            mode_r    <= MODE_MIN;
            first     <= 1'b0;
            best      <= '0;
            count     <= '0;
            best_perm <= IDENT;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_r <= mode;
                        perm   <= IDENT;
                        acc    <= '0;
                        w_cnt  <= '0;
                        first  <= 1'b1;
                        state  <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    acc <= acc + {{(SUM_W-COST_W){1'b0}}, Cost};
                    if (w_cnt == W_LAST) begin
                        w_cnt <= '0;
                        state <= S_STEP;
                    end else begin
                        w_cnt <= w_cnt + IDX_W'(1);
                    end
                end
                S_STEP: begin
                    // Ties keep the earlier permutation, which is lexicographically smaller.
                    if (first || better) begin
                        best      <= acc;
                        count     <= 16'd1;
                        best_perm <= perm;
                    end else if (acc == best) begin
                        count <= count + 16'd1;
                    end
                    first <= 1'b0;
                    acc   <= '0;
                    perm  <= perm_nxt;
                    state <= perm_last ? S_DONE : S_EVAL;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign W          = (state == S_EVAL) ? w_cnt : '0;
    assign J          = (state == S_EVAL) ? j_sel : '0;
    assign BestCost   = best;
    assign MatchCount = count;
    assign BestPerm   = best_perm;
    assign busy       = (state != S_IDLE);
    assign Valid      = (state == S_DONE);

endmodule

// File: tb/tb_jam_param.sv
// Directed bench for jam_param using small N=3 and N=4 instances so full runs stay short.
module tb_jam_param;

    logic CLK;
    logic RST;

    logic       start3, mode3;
    logic [1:0] W3, J3;
    logic [6:0] cost3;
    logic [8:0] best3;
    logic [15:0] cnt3;
    logic [5:0] perm3;
    logic       busy3, valid3;

    logic       start4, mode4;
    logic [1:0] W4, J4;
    logic [6:0] cost4;
    logic [8:0] best4;
    logic [15:0] cnt4;
    logic [7:0] perm4;
    logic       busy4, valid4;
    int         pat4;

    int total;
    int bad;

    jam_param #(.N(3), .COST_W(7)) u3 (
        .CLK(CLK), .RST(RST), .start(start3), .mode(mode3), .W(W3), .J(J3), .Cost(cost3),
        .BestCost(best3), .MatchCount(cnt3), .BestPerm(perm3), .busy(busy3), .Valid(valid3)
    );

    jam_param #(.N(4), .COST_W(7)) u4 (
        .CLK(CLK), .RST(RST), .start(start4), .mode(mode4), .W(W4), .J(J4), .Cost(cost4),
        .BestCost(best4), .MatchCount(cnt4), .BestPerm(perm4), .busy(busy4), .Valid(valid4)
    );

    // Cost tables: N=3 uses W*J, N=4 selects a pattern per test.
    always_comb begin
        cost3 = {5'd0, W3} * {5'd0, J3};
        case (pat4)
            0:       cost4 = 7'd5;
            1:       cost4 = (J4 == 2'd3 - W4) ? 7'd0 : 7'd10;
            default: cost4 = (W4 == J4) ? 7'd0 : 7'd10;
        endcase
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic run3(input logic m, output int vcyc, output int vcnt,
                        output logic [8:0] b, output logic [15:0] c, output logic [5:0] p);
        @(negedge CLK);
        start3 = 1'b1;
        mode3  = m;
        @(posedge CLK);
        #1;
        start3 = 1'b0;
        mode3  = ~m;
        vcyc = -1;
        vcnt = 0;
        for (int cyc = 1; cyc <= 400 && vcyc < 0; cyc++) begin
            @(negedge CLK);
            if (valid3) begin
                vcnt++;
                vcyc = cyc;
            end
        end
        b = best3;
        c = cnt3;
        p = perm3;
    endtask

    task automatic run4(input logic m, input int restart_at, output int vcyc, output int vcnt,
                        output logic [8:0] b, output logic [15:0] c, output logic [7:0] p);
        @(negedge CLK);
        start4 = 1'b1;
        mode4  = m;
        @(posedge CLK);
        #1;
        start4 = 1'b0;
        vcyc = -1;
        vcnt = 0;
        for (int cyc = 1; cyc <= 400 && vcyc < 0; cyc++) begin
            @(negedge CLK);
            start4 = (cyc == restart_at);
            if (valid4) begin
                vcnt++;
                vcyc = cyc;
            end
        end
        start4 = 1'b0;
        b = best4;
        c = cnt4;
        p = perm4;
    endtask

    task automatic test_reset();
        total++; if (best3 !== 9'd0) begin bad++; $display("FAIL rst_best3 got=%0d exp=0", best3); end
        total++; if (cnt3 !== 16'd0) begin bad++; $display("FAIL rst_cnt3 got=%0d exp=0", cnt3); end
        total++; if (perm3 !== 6'h24) begin bad++; $display("FAIL rst_perm3 got=%h exp=24", perm3); end
        total++; if (perm4 !== 8'hE4) begin bad++; $display("FAIL rst_perm4 got=%h exp=e4", perm4); end
        total++; if ({busy3, valid3, W3, J3} !== 6'd0) begin bad++; $display("FAIL rst_ctl3 got=%b exp=000000", {busy3, valid3, W3, J3}); end
    endtask

    task automatic test_idle();
        repeat (5) @(negedge CLK);
        total++; if ({busy4, valid4, W4, J4} !== 6'd0) begin bad++; $display("FAIL idle_ctl4 got=%b exp=000000", {busy4, valid4, W4, J4}); end
    endtask

    task automatic test_min_wj();
        int vc, vn; logic [8:0] b; logic [15:0] c; logic [5:0] p;
        run3(1'b0, vc, vn, b, c, p);
        total++; if (vc !== 25) begin bad++; $display("FAIL wj_min_valid_cyc got=%0d exp=25", vc); end
        total++; if (b !== 9'd1) begin bad++; $display("FAIL wj_min_best got=%0d exp=1", b); end
        total++; if (c !== 16'd1) begin bad++; $display("FAIL wj_min_cnt got=%0d exp=1", c); end
        total++; if (p !== 6'h06) begin bad++; $display("FAIL wj_min_perm got=%h exp=06", p); end
        @(negedge CLK);
        total++; if ({busy3, valid3} !== 2'b00) begin bad++; $display("FAIL wj_min_after got=%b exp=00", {busy3, valid3}); end
    endtask

    task automatic test_back_to_back();
        int vc, vn; logic [8:0] b; logic [15:0] c; logic [5:0] p;
        run3(1'b0, vc, vn, b, c, p);
        total++; if ({b, c, p} !== {9'd1, 16'd1, 6'h06}) begin bad++; $display("FAIL b2b_first got=%0d/%0d/%h exp=1/1/06", b, c, p); end
        run3(1'b1, vc, vn, b, c, p);
        total++; if (vc !== 25) begin bad++; $display("FAIL b2b_valid_cyc got=%0d exp=25", vc); end
        total++; if (b !== 9'd5) begin bad++; $display("FAIL b2b_max_best got=%0d exp=5", b); end
        total++; if (c !== 16'd1) begin bad++; $display("FAIL b2b_max_cnt got=%0d exp=1", c); end
        total++; if (p !== 6'h24) begin bad++; $display("FAIL b2b_max_perm got=%h exp=24", p); end
    endtask

    task automatic test_all_equal();
        int vc, vn; logic [8:0] b; logic [15:0] c; logic [7:0] p;
        pat4 = 0;
        run4(1'b0, 0, vc, vn, b, c, p);
        total++; if (vc !== 121) begin bad++; $display("FAIL eq_valid_cyc got=%0d exp=121", vc); end
        total++; if (b !== 9'd20) begin bad++; $display("FAIL eq_best got=%0d exp=20", b); end
        total++; if (c !== 16'd24) begin bad++; $display("FAIL eq_cnt got=%0d exp=24", c); end
        total++; if (p !== 8'hE4) begin bad++; $display("FAIL eq_perm got=%h exp=e4", p); end
    endtask

    task automatic test_anti_diag();
        int vc, vn; logic [8:0] b; logic [15:0] c; logic [7:0] p;
        pat4 = 1;
        run4(1'b0, 0, vc, vn, b, c, p);
        total++; if (b !== 9'd0) begin bad++; $display("FAIL anti_best got=%0d exp=0", b); end
        total++; if (c !== 16'd1) begin bad++; $display("FAIL anti_cnt got=%0d exp=1", c); end
        total++; if (p !== 8'h1B) begin bad++; $display("FAIL anti_perm got=%h exp=1b", p); end
    endtask

    task automatic test_start_ignored();
        int vc, vn, extra; logic [8:0] b; logic [15:0] c; logic [7:0] p;
        pat4 = 2;
        run4(1'b0, 30, vc, vn, b, c, p);
        extra = 0;
        repeat (20) begin
            @(negedge CLK);
            if (valid4) extra++;
        end
        total++; if (vc !== 121) begin bad++; $display("FAIL restart_valid_cyc got=%0d exp=121", vc); end
        total++; if (vn + extra !== 1) begin bad++; $display("FAIL restart_valid_cnt got=%0d exp=1", vn + extra); end
        total++; if ({b, c, p} !== {9'd0, 16'd1, 8'hE4}) begin bad++; $display("FAIL restart_result got=%0d/%0d/%h exp=0/1/e4", b, c, p); end
    endtask

    task automatic test_async_reset();
        int vc, vn; logic [8:0] b; logic [15:0] c; logic [5:0] p;
        @(negedge CLK);
        start3 = 1'b1;
        mode3  = 1'b0;
        @(posedge CLK);
        #1;
        start3 = 1'b0;
        repeat (6) @(negedge CLK);
        total++; if ({busy3, W3, best3} !== {1'b1, 2'd1, 9'd5}) begin bad++; $display("FAIL arst_pre got=%b/%0d/%0d exp=1/1/5", busy3, W3, best3); end
        #2;
        RST = 1'b1;
        #1;
        total++; if ({busy3, valid3, W3, J3} !== 6'd0) begin bad++; $display("FAIL arst_ctl got=%b exp=000000", {busy3, valid3, W3, J3}); end
        total++; if ({best3, cnt3, perm3} !== {9'd0, 16'd0, 6'h24}) begin bad++; $display("FAIL arst_regs got=%0d/%0d/%h exp=0/0/24", best3, cnt3, perm3); end
        #3;
        RST = 1'b0;
        run3(1'b0, vc, vn, b, c, p);
        total++; if (vc !== 25) begin bad++; $display("FAIL arst_valid_cyc got=%0d exp=25", vc); end
        total++; if ({b, c, p} !== {9'd1, 16'd1, 6'h06}) begin bad++; $display("FAIL arst_result got=%0d/%0d/%h exp=1/1/06", b, c, p); end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        RST    = 1'b1;
        start3 = 1'b0;
        mode3  = 1'b0;
        start4 = 1'b0;
        mode4  = 1'b0;
        pat4   = 0;
        #12;
        test_reset();
        @(negedge CLK);
        RST = 1'b0;
        test_idle();
        test_min_wj();
        test_back_to_back();
        test_all_equal();
        test_anti_diag();
        test_start_ignored();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
